// File: rtl/control_unit_mc.sv
// control_unit_mc: multi-cycle sequencer for the PG1 datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, holds the
// per-opcode datapath selects and pulses write strobes. Memory accesses wait
// on i_mem_ready, bounded by MEM_TIMEOUT. Illegal opcodes and memory timeouts
// both end in a sticky ERR state that only reset clears.
module control_unit_mc #(
  parameter int OPCODE_W    = 5,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_run,
  input  logic [OPCODE_W-1:0] i_opcode,
  input  logic [ALUOP_W-1:0]  i_aluop,
  input  logic                i_zero,
  input  logic                i_mem_ready,
  output logic                o_mem_rd,
  output logic                o_we,
  output logic                o_data_in_s,
  output logic                o_data_in_on,
  output logic                o_opb_select,
  output logic                o_select_mem,
  output logic [ALUOP_W-1:0]  o_alu_signal,
  output logic                o_rwrite,
  output logic                o_branch,
  output logic                o_pc_write,
  output logic                o_ir_write,
  output logic                o_instr_done,
  output logic                o_err,
  output logic [1:0]          o_err_code
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LDR  = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_STR  = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(4);

  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_ERR
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [OPCODE_W-1:0] r_opcode;
  logic [ALUOP_W-1:0]  r_aluop;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [1:0]          r_err_code;
  logic [1:0]          w_err_code_nxt;
  logic                w_timeout;
  logic                w_waiting;
  state_t              w_after_done;

  // The wait counter has already seen MEM_TIMEOUT-1 idle cycles, so this is
  // the last allowed one; a ready in this same cycle still wins.
  assign w_timeout    = (r_wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
  assign w_waiting    = ((r_state == S_FETCH) || (r_state == S_MEM)) && !i_mem_ready;
  assign w_after_done = i_run ? S_FETCH : S_IDLE;
  assign o_err_code   = r_err_code;

  // State, wait counter, latched instruction fields and error code.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_opcode   <= '0;
      r_aluop    <= '0;
      r_wait_cnt <= '0;
      r_err_code <= 2'b00;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_opcode <= i_opcode;
        r_aluop  <= i_aluop;
      end
      // Counts only while parked in FETCH/MEM; any exit or ready clears it,
      // so every entry starts from zero.
      if (w_waiting && (w_next == r_state)) r_wait_cnt <= r_wait_cnt + 1'b1;
      else                                  r_wait_cnt <= '0;
      if ((r_state != S_ERR) && (w_next == S_ERR)) r_err_code <= w_err_code_nxt;
    end
  end

  // Next-state and output decode from state, latched fields and live flags.
  // NOTE: every signal written here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    w_next         = r_state;
    w_err_code_nxt = 2'b00;
    o_mem_rd       = 1'b0;
    o_we           = 1'b0;
    o_data_in_s    = 1'b0;
    o_data_in_on   = 1'b0;
    o_opb_select   = 1'b0;
    o_select_mem   = 1'b0;
    o_alu_signal   = '0;
    o_rwrite       = 1'b0;
    o_branch       = 1'b0;
    o_pc_write     = 1'b0;
    o_ir_write     = 1'b0;
    o_instr_done   = 1'b0;
    o_err          = 1'b0;

    // Static selects are valid only while the latched opcode is executing.
    if ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)) begin
      case (r_opcode)
        OP_R:    begin o_data_in_s = 1'b1; o_data_in_on = 1'b1; o_alu_signal = r_aluop; end
        OP_LDR:  begin o_data_in_on = 1'b1; o_opb_select = 1'b1; o_select_mem = 1'b1; end
        OP_STR:  begin o_data_in_s = 1'b1; o_opb_select = 1'b1; end
        OP_BEQ:  begin o_data_in_s = 1'b1; o_alu_signal = ALUOP_W'(1); end
        OP_ADDI: begin o_data_in_s = 1'b1; o_data_in_on = 1'b1; o_opb_select = 1'b1; end
        default: ;
      endcase
    end

    case (r_state)
      S_IDLE: if (i_run) w_next = S_FETCH;
      S_FETCH: begin
        o_mem_rd = 1'b1;
        if (i_mem_ready) begin
          o_ir_write = 1'b1;
          o_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_timeout) begin
          w_next         = S_ERR;
          w_err_code_nxt = ERR_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (i_opcode inside {OP_R, OP_LDR, OP_STR, OP_BEQ, OP_ADDI}) begin
          w_next = S_EXEC;
        end else begin
          w_next         = S_ERR;
          w_err_code_nxt = ERR_ILLEGAL;
        end
      end
      S_EXEC: begin
        case (r_opcode)
          OP_BEQ: begin
            o_branch     = i_zero;
            o_pc_write   = i_zero;
            o_instr_done = 1'b1;
            w_next       = w_after_done;
          end
          OP_LDR, OP_STR: w_next = S_MEM;
          default:        w_next = S_WB;
        endcase
      end
      S_MEM: begin
        o_mem_rd = (r_opcode == OP_LDR);
        o_we     = (r_opcode == OP_STR);
        if (i_mem_ready) begin
          if (r_opcode == OP_STR) begin
            o_instr_done = 1'b1;
            w_next       = w_after_done;
          end else begin
            w_next = S_WB;
          end
        end else if (w_timeout) begin
          w_next         = S_ERR;
          w_err_code_nxt = ERR_TIMEOUT;
        end
      end
      S_WB: begin
        o_rwrite     = 1'b1;
        o_instr_done = 1'b1;
        w_next       = w_after_done;
      end
      S_ERR: begin
        // Selects from the EXEC-phase decode never apply here.
        o_err = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc: walks each instruction class cycle by
// cycle and compares the packed output vector against hand-built values.
module tb_control_unit_mc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [4:0] opcode = '0;
  logic [2:0] aluop = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_rd, we, data_in_s, data_in_on, opb_select, select_mem;
  logic [2:0] alu_signal;
  logic       rwrite, branch, pc_write, ir_write, instr_done, err;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_errors = 0;

  // Output vector bit positions.
  localparam logic [16:0] MRD  = 17'h1_0000;
  localparam logic [16:0] WE   = 17'h0_8000;
  localparam logic [16:0] DS   = 17'h0_4000;
  localparam logic [16:0] DON  = 17'h0_2000;
  localparam logic [16:0] OPB  = 17'h0_1000;
  localparam logic [16:0] SMEM = 17'h0_0800;
  localparam logic [16:0] RW   = 17'h0_0080;
  localparam logic [16:0] BR   = 17'h0_0040;
  localparam logic [16:0] PCW  = 17'h0_0020;
  localparam logic [16:0] IRW  = 17'h0_0010;
  localparam logic [16:0] DONE = 17'h0_0008;
  localparam logic [16:0] ERR  = 17'h0_0004;
  localparam logic [16:0] NONE = 17'h0_0000;

  localparam logic [16:0] FETCH_OK = MRD | IRW | PCW;

  function automatic logic [16:0] alu(input logic [2:0] v);
    return {9'b0, v, 5'b0} << 3;
  endfunction

  function automatic logic [16:0] code(input logic [1:0] v);
    return {15'b0, v};
  endfunction

  control_unit_mc #(.OPCODE_W(5), .ALUOP_W(3), .MEM_TIMEOUT(15)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_opcode(opcode),
    .i_aluop(aluop), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_mem_rd(mem_rd), .o_we(we), .o_data_in_s(data_in_s),
    .o_data_in_on(data_in_on), .o_opb_select(opb_select),
    .o_select_mem(select_mem), .o_alu_signal(alu_signal), .o_rwrite(rwrite),
    .o_branch(branch), .o_pc_write(pc_write), .o_ir_write(ir_write),
    .o_instr_done(instr_done), .o_err(err), .o_err_code(err_code)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] outs();
    return {mem_rd, we, data_in_s, data_in_on, opb_select, select_mem,
            alu_signal, rwrite, branch, pc_write, ir_write, instr_done, err,
            err_code};
  endfunction

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, then move past the
  // next rising edge.
  task automatic cyc(input string tag, input logic r, input logic rdy,
                     input logic z, input logic [4:0] op, input logic [2:0] ao,
                     input logic [16:0] exp);
    run = r; mem_ready = rdy; zero = z; opcode = op; aluop = ao;
    #1;
    check(tag, outs(), exp);
    @(posedge clk); #2;
  endtask

  initial begin
    #1;
    check("reset", outs(), NONE);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // R-type, ALUOP=101, zero-wait: 4 cycles.
    cyc("r_idle",   1, 1, 0, 5'd0, 3'b101, NONE);
    cyc("r_fetch",  1, 1, 0, 5'd0, 3'b101, FETCH_OK);
    cyc("r_decode", 1, 1, 0, 5'd0, 3'b101, NONE);
    cyc("r_exec",   1, 1, 0, 5'd7, 3'b000, DS | DON | alu(3'b101));
    cyc("r_wb",     1, 1, 0, 5'd7, 3'b000, DS | DON | alu(3'b101) | RW | DONE);

    // LDR with three MEM wait cycles: 8 cycles.
    cyc("ldr_fetch",  1, 1, 0, 5'd1, 3'b111, FETCH_OK);
    cyc("ldr_decode", 1, 1, 0, 5'd1, 3'b111, NONE);
    cyc("ldr_exec",   1, 0, 0, 5'd0, 3'b000, DON | OPB | SMEM);
    for (int i = 0; i < 3; i++)
      cyc("ldr_mem_wait", 1, 0, 0, 5'd0, 3'b000, MRD | DON | OPB | SMEM);
    cyc("ldr_mem_rdy", 1, 1, 0, 5'd0, 3'b000, MRD | DON | OPB | SMEM);
    cyc("ldr_wb",      1, 1, 0, 5'd0, 3'b000, DON | OPB | SMEM | RW | DONE);

    // BEQ taken then not taken: 3 cycles each.
    cyc("beq1_fetch",  1, 1, 0, 5'd3, 3'b000, FETCH_OK);
    cyc("beq1_decode", 1, 1, 0, 5'd3, 3'b000, NONE);
    cyc("beq1_exec",   1, 1, 1, 5'd0, 3'b000, DS | alu(3'b001) | BR | PCW | DONE);
    cyc("beq0_fetch",  1, 1, 0, 5'd3, 3'b000, FETCH_OK);
    cyc("beq0_decode", 1, 1, 0, 5'd3, 3'b000, NONE);
    cyc("beq0_exec",   1, 1, 0, 5'd0, 3'b000, DS | alu(3'b001) | DONE);

    // ADDI with RUN dropped mid-instruction: completes, then IDLE.
    cyc("addi_fetch",  1, 1, 0, 5'd4, 3'b000, FETCH_OK);
    cyc("addi_decode", 0, 1, 0, 5'd4, 3'b000, NONE);
    cyc("addi_exec",   0, 1, 0, 5'd0, 3'b000, DS | DON | OPB);
    cyc("addi_wb",     0, 1, 0, 5'd0, 3'b000, DS | DON | OPB | RW | DONE);
    cyc("addi_idle",   0, 1, 0, 5'd0, 3'b000, NONE);
    cyc("addi_idle2",  1, 1, 0, 5'd0, 3'b000, NONE);

    // STR with ready arriving in the 15th wait cycle: completes.
    cyc("str_fetch",  1, 1, 0, 5'd2, 3'b000, FETCH_OK);
    cyc("str_decode", 1, 1, 0, 5'd2, 3'b000, NONE);
    cyc("str_exec",   1, 0, 0, 5'd0, 3'b000, DS | OPB);
    for (int i = 0; i < 14; i++)
      cyc("str_mem_wait", 1, 0, 0, 5'd0, 3'b000, WE | DS | OPB);
    cyc("str_mem_last", 1, 1, 0, 5'd0, 3'b000, WE | DS | OPB | DONE);

    // STR with no ready for 15 cycles: timeout error.
    cyc("sto_fetch",  1, 1, 0, 5'd2, 3'b000, FETCH_OK);
    cyc("sto_decode", 1, 1, 0, 5'd2, 3'b000, NONE);
    cyc("sto_exec",   1, 0, 0, 5'd0, 3'b000, DS | OPB);
    for (int i = 0; i < 15; i++)
      cyc("sto_mem_wait", 1, 0, 0, 5'd0, 3'b000, WE | DS | OPB);
    cyc("sto_err",    1, 1, 0, 5'd0, 3'b000, ERR | code(2'b10));
    cyc("sto_err2",   1, 1, 1, 5'd0, 3'b000, ERR | code(2'b10));

    rst_n = 1'b0; #1;
    check("sto_reset", outs(), NONE);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Illegal opcode 11111: error after DECODE, sticky until reset.
    cyc("ill_idle",   1, 1, 0, 5'd31, 3'b000, NONE);
    cyc("ill_fetch",  1, 1, 0, 5'd31, 3'b000, FETCH_OK);
    cyc("ill_decode", 1, 1, 0, 5'd31, 3'b000, NONE);
    for (int i = 0; i < 3; i++)
      cyc("ill_err", 1, 1, 1, 5'd0, 3'b000, ERR | code(2'b01));

    rst_n = 1'b0; #1;
    check("ill_reset", outs(), NONE);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Reset in the middle of an LDR memory wait.
    cyc("rw_idle0",   0, 1, 0, 5'd1, 3'b000, NONE);
    cyc("rw_idle1",   1, 1, 0, 5'd1, 3'b000, NONE);
    cyc("rw_fetch",   1, 1, 0, 5'd1, 3'b000, FETCH_OK);
    cyc("rw_decode",  1, 1, 0, 5'd1, 3'b000, NONE);
    cyc("rw_exec",    1, 0, 0, 5'd0, 3'b000, DON | OPB | SMEM);
    cyc("rw_mem",     1, 0, 0, 5'd0, 3'b000, MRD | DON | OPB | SMEM);
    run = 1'b0;
    rst_n = 1'b0; #1;
    check("rw_reset", outs(), NONE);
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      cyc("rw_idle_hold", 0, 1, 0, 5'd0, 3'b000, NONE);
    cyc("rw_idle_go",  1, 1, 0, 5'd0, 3'b000, NONE);
    cyc("rw_fetch2",   1, 1, 0, 5'd0, 3'b000, FETCH_OK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_unit_mc.md
# control_unit_mc

Multi-cycle, parametrised control unit for the PG1 datapath. Sequences each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB states, holding per-opcode datapath selects and pulsing write strobes in the proper cycle. It handles variable-latency memory through a ready handshake with a timeout, and traps on illegal opcodes. It sits between the instruction register/flags and the register file, ALU, memory and PC.

## Interface
- OPCODE_W, 5, opcode field width; encodings below use the low 5 bits, upper bits must be 0
- ALUOP_W, 3, width of ALUOP and ALU_SIGNAL
- MEM_TIMEOUT, 15, max wait cycles for MEM_READY (≥2)
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- RUN  in  1  enable; sampled in IDLE and at instruction end
- OPCODE  in  OPCODE_W  from IR, valid in DECODE
- ALUOP  in  ALUOP_W  R-type function, valid in DECODE
- ZERO  in  1  ALU zero flag, valid in EXEC
- MEM_READY  in  1  memory access complete
- MEM_RD  out  1  memory read request (FETCH; MEM for LDR)
- WE  out  1  memory write strobe (MEM for STR)
- DATA_IN_S, DATA_IN_ON, OPB_SELECT, SELECT_MEM  out  1 each  datapath selects
- ALU_SIGNAL  out  ALUOP_W  ALU operation
- RWRITE  out  1  register-file write (WB)
- BRANCH  out  1  branch-target PC select
- PC_WRITE  out  1  PC update
- IR_WRITE  out  1  IR load
- INSTR_DONE  out  1  one-cycle pulse on last cycle of an instruction
- ERR  out  1  sticky error
- ERR_CODE  out  2  01 illegal opcode, 10 memory timeout

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERR. Reset → IDLE.
- IDLE: RUN=1 → FETCH.
- FETCH: MEM_RD=1. On MEM_READY: IR_WRITE=1, PC_WRITE=1 (same cycle), → DECODE.
- DECODE: latch OPCODE, ALUOP into internal regs; illegal opcode → ERR with ERR_CODE=01.
- Static selects, driven from latched regs in EXEC/MEM/WB, 0 in all other states: DATA_IN_S, DATA_IN_ON, OPB_SELECT, SELECT_MEM, ALU_SIGNAL.
  - R 00000: 1,1,0,0, ALUOP
  - LDR 00001: 0,1,1,1, 000
  - STR 00010: 1,0,1,0, 000
  - BEQ 00011: 1,0,0,0, 001 (subtract)
  - ADDI 00100: 1,1,1,0, 000
- Sequences: R/ADDI EXEC→WB; LDR EXEC→MEM→WB; STR EXEC→MEM; BEQ EXEC only.
- EXEC for BEQ: ZERO=1 → BRANCH=1, PC_WRITE=1; ZERO=0 → neither.
- MEM: LDR asserts MEM_RD, STR asserts WE, held until MEM_READY; leaves on MEM_READY.
- WB: RWRITE=1 for one cycle.
- Last cycle of instruction (WB, STR MEM with MEM_READY, BEQ EXEC): INSTR_DONE=1; next state FETCH if RUN=1, else IDLE.
- Wait counter: clears on entry to FETCH/MEM; increments each cycle there with MEM_READY=0. After MEM_TIMEOUT consecutive waiting cycles without MEM_READY → ERR, ERR_CODE=10. MEM_READY in the final allowed cycle wins over the timeout.
- ERR: ERR=1, all strobes/selects 0; left only by reset.

## Timing
- State, counter and latched regs update on rising CLK; outputs decode combinationally from state, latched regs, MEM_READY and ZERO.
- Reset (any time, including mid-instruction or mid-wait): every output 0, ERR_CODE=00, counter 0, state IDLE, immediately and asynchronously.
- Zero-wait memory: R/ADDI 4 cycles, LDR 5, STR 4, BEQ 3 (FETCH to INSTR_DONE inclusive); each memory wait cycle adds one.
- RUN dropped mid-instruction: current instruction completes, then IDLE.
- WE, RWRITE, IR_WRITE never overlap; PC_WRITE only in FETCH-with-ready or taken-BEQ EXEC.

## Test plan
- Reset, RUN=1, MEM_READY=1, R opcode with ALUOP=101: FETCH(IR_WRITE,PC_WRITE)→DECODE→EXEC(ALU_SIGNAL=101, DATA_IN_S=1)→WB(RWRITE=1, INSTR_DONE=1); 4 cycles.
- LDR with MEM_READY low 3 cycles in MEM: MEM_RD held 4 cycles, SELECT_MEM=1, then WB RWRITE=1; total 8 cycles.
- BEQ ZERO=1 → BRANCH=1, PC_WRITE=1 in EXEC; repeat with ZERO=0 → both 0; each 3 cycles.
- STR with MEM_READY rising in cycle 15 of wait (MEM_TIMEOUT=15) → completes; with none for 15 cycles → ERR=1, ERR_CODE=10, WE=0.
- Opcode 11111 → ERR after DECODE, ERR_CODE=01, sticky until RST_N low.
- RST_N low during LDR MEM wait → all outputs 0 immediately; after release IDLE until RUN=1.
